// File: rtl/preg_freelist_ctrl.sv
// rtl/preg_freelist_ctrl.sv - physical-register free pool for a 2-wide rename stage
//
// Purpose:
//   Circular FIFO of free physical register numbers. Rename draws up to two
//   pregs per cycle with an all-or-nothing grant; retire returns up to two
//   pregs per cycle. Returned pregs become allocatable the following cycle.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   alloc_req_1/2  rename slot 1/2 needs a destination preg
//   alloc_grant    every asserted request is served this cycle
//   alloc_preg_1/2 preg handed to slot 1/2 (meaningful when requested and granted)
//   stall          a request is pending but cannot be fully served
//   free_valid_1/2 retire returns free_preg_1/2
//   free_preg_1/2  preg being returned (p0 is silently ignored)
//   free_count     registered number of pregs in the pool
//   overflow_err   sticky: a returned preg was dropped because the pool was full
module preg_freelist_ctrl #(
   parameter int NUM_PREGS = 128,
   parameter int NUM_AREGS = 32,
   parameter int PW        = $clog2(NUM_PREGS),
   parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          alloc_req_1,
   input  logic          alloc_req_2,
   output logic          alloc_grant,
   output logic [PW-1:0] alloc_preg_1,
   output logic [PW-1:0] alloc_preg_2,
   output logic          stall,
   input  logic          free_valid_1,
   input  logic          free_valid_2,
   input  logic [PW-1:0] free_preg_1,
   input  logic [PW-1:0] free_preg_2,
   output logic [PW:0]   free_count,
   output logic          overflow_err
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   logic [PW-1:0] fifo_q [DEPTH];
   logic [IW-1:0] head_q, head_d;
   logic [IW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic [IW-1:0] head_p1, head_p2;
   logic [IW-1:0] tail_p1, tail_p2;
   logic [IW-1:0] wr2_idx;
   logic [1:0]    need;
   logic [1:0]    pop_n;
   logic [CW-1:0] count_after_pop;
   logic [CW-1:0] space;
   logic          acc_1, acc_2;
   logic          push_1, push_2;

   // Index increment with explicit wrap, since DEPTH need not be a power of two.
   function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   always_comb begin
      head_p1 = idx_inc(head_q);
      head_p2 = idx_inc(head_p1);
      tail_p1 = idx_inc(tail_q);
      tail_p2 = idx_inc(tail_p1);
   end

   // Allocation: purely combinational from registered state.
   always_comb begin
      need        = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
      alloc_grant = (need == 2'd0) || (count_q >= CW'(need));
      stall       = (alloc_req_1 | alloc_req_2) & ~alloc_grant;
      pop_n       = alloc_grant ? need : 2'd0;
      alloc_preg_1 = fifo_q[head_q];
      // Slot 2 takes the second entry only when slot 1 is consuming the first.
      alloc_preg_2 = alloc_req_1 ? fifo_q[head_p1] : fifo_q[head_q];
   end

   // Free: capacity is judged after this cycle's pops, so a full pool that is
   // being drained in the same cycle can still accept returns. Slot 1 has
   // priority for the remaining space, so slot 2 is the one dropped first.
   always_comb begin
      count_after_pop = count_q - CW'(pop_n);
      space           = CW'(DEPTH) - count_after_pop;
      acc_1           = free_valid_1 && (free_preg_1 != '0);
      acc_2           = free_valid_2 && (free_preg_2 != '0);
      push_1          = acc_1 && (space != '0);
      push_2          = acc_2 && (space > CW'(push_1));
      wr2_idx         = push_1 ? tail_p1 : tail_q;
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      ovf_d  = ovf_q;

      case (pop_n)
         2'd1:    head_d = head_p1;
         2'd2:    head_d = head_p2;
         default: head_d = head_q;
      endcase

      case ({push_1, push_2})
         2'b11:         tail_d = tail_p2;
         2'b10, 2'b01:  tail_d = tail_p1;
         default:       tail_d = tail_q;
      endcase

      count_d = count_after_pop + CW'(push_1) + CW'(push_2);

      if ((acc_1 && !push_1) || (acc_2 && !push_2)) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CW'(DEPTH);
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Pool storage. Pushes only land in slots that are not live (count
   // accounting guarantees it), so reads this cycle never see a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= PW'(NUM_AREGS + i);
         end
      end else begin
         if (push_1) begin
            fifo_q[tail_q] <= free_preg_1;
         end
         if (push_2) begin
            fifo_q[wr2_idx] <= free_preg_2;
         end
      end
   end

   assign free_count   = count_q;
   assign overflow_err = ovf_q;

endmodule
